// File: rtl/multicycle_controller.sv
// Main sequencing FSM for the multi-cycle RV32I core.
// Optional perf counters: define MC_PERF_COUNTERS_EN.
module multicycle_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic [2:0]  MemMode,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUControl,
    output logic [2:0]  ImmSrc,
    output logic [1:0]  ResultSrc,
    output logic        RegWrite,
    output logic        illegal,
    output logic [31:0] cycle_count,
    output logic [31:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_LUI, S_ALUWB, S_BRANCH, S_JAL, S_JALR,
        S_JALR_LINK, S_ILLEGAL
    } state_e;

    state_e state_q, state_d, dec_next;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Unsupported opcode/funct3 combinations fall through to ILLEGAL
    always_comb begin
        dec_next = S_ILLEGAL;
        case (op)
            7'd3:   if (funct3 inside {3'b010, 3'b000, 3'b100}) dec_next = S_MEMADR;
            7'd35:  if (funct3 inside {3'b010, 3'b000}) dec_next = S_MEMADR;
            7'd51:  if (!funct7 && (funct3 inside {3'b000, 3'b001, 3'b100,
                                                   3'b101, 3'b111}))
                        dec_next = S_EXECR;
            7'd19:  if (funct3 == 3'b000) dec_next = S_EXECI;
            7'd99:  if (funct3 inside {3'b000, 3'b001}) dec_next = S_BRANCH;
            7'd111: dec_next = S_JAL;
            7'd103: dec_next = S_JALR;
            7'd55:  dec_next = S_LUI;
            default: dec_next = S_ILLEGAL;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        MemMode    = 3'b000;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b000;
        ImmSrc     = 3'b000;
        ResultSrc  = 2'b00;
        RegWrite   = 1'b0;
        illegal    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b010;
                state_d = dec_next;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == 7'd35) ? 3'b001 : 3'b000;
                state_d = (op == 7'd35) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                case (funct3)
                    3'b000:  MemMode = 3'b010;
                    3'b100:  MemMode = 3'b110;
                    default: MemMode = 3'b000;
                endcase
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                MemMode = (funct3 == 3'b000) ? 3'b011 : 3'b001;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = funct3;
                state_d    = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b100;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = 3'b100;
                PCWrite    = (funct3 == 3'b000) ? Zero : ~Zero;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
                state_d   = S_JALR_LINK;
            end
            S_JALR_LINK: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_ILLEGAL: illegal = 1'b1;
            default:   state_d = S_ILLEGAL;
        endcase
        // Reset abandons any pending access and silences every output
        if (rst) begin
            mem_req    = 1'b0;
            MemMode    = 3'b000;
            AdrSrc     = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ALUControl = 3'b000;
            ImmSrc     = 3'b000;
            ResultSrc  = 2'b00;
            RegWrite   = 1'b0;
            illegal    = 1'b0;
        end
    end

`ifdef MC_PERF_COUNTERS_EN
    logic [31:0] cyc_q, cyc_d, ret_q, ret_d;

    always_comb begin
        cyc_d = cyc_q;
        ret_d = ret_q;
        if (state_q != S_ILLEGAL) cyc_d = cyc_q + 32'd1;
        if (state_d == S_FETCH && state_q != S_FETCH) ret_d = ret_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= 32'd0;
            ret_q <= 32'd0;
        end else begin
            cyc_q <= cyc_d;
            ret_q <= ret_d;
        end
    end

    assign cycle_count = cyc_q;
    assign instret     = ret_q;
`else
    assign cycle_count = 32'd0;
    assign instret     = 32'd0;
`endif

endmodule
